// File: rtl/data_memory_hs.sv
// Word-organised data memory with valid/ready request and response handshakes,
// byte-lane writes, configurable read latency and alignment/range error reporting.
module data_memory_hs #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 32,
    parameter int RD_LAT    = 1,
    parameter int ZERO_INIT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_we,
    output logic                  rsp_err
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDX   = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_we_q, rsp_we_d;
    logic              rsp_err_q, rsp_err_d;

    logic [IDX-1:0]    word_idx;
    logic              misaligned;
    logic              out_of_range;
    logic              req_err;
    logic              accept;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;

    assign word_idx = req_addr[OFF +: IDX];

    if (OFF > 0) begin : g_align
        assign misaligned = |req_addr[OFF-1:0];
    end else begin : g_no_align
        assign misaligned = 1'b0;
    end

    if (OFF + IDX < ADDR_W) begin : g_range
        assign out_of_range = |req_addr[ADDR_W-1:OFF+IDX];
    end else begin : g_no_range
        assign out_of_range = 1'b0;
    end

    assign req_err = misaligned | out_of_range;
    // Nothing is accepted while reset is held, so memory cannot change under reset.
    assign accept  = req_valid & req_ready_q & ~reset;
    assign wr_en   = accept & req_we & ~req_err;

    if (ZERO_INIT != 0) begin : g_mem_zero
        logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

        always_ff @(posedge clk) begin
            if (wr_en) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (req_be[i]) begin
                        mem[word_idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
                    end
                end
            end
        end

        assign rd_word = mem[word_idx];
    end else begin : g_mem_x
        logic [DATA_W-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (wr_en) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (req_be[i]) begin
                        mem[word_idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
                    end
                end
            end
        end

        assign rd_word = mem[word_idx];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rsp_we_d    = req_we;
                    rsp_err_d   = req_err;
                    rsp_rdata_d = (req_we || req_err) ? '0 : rd_word;
                    req_ready_d = 1'b0;
                    if (RD_LAT == 1) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 2'(RD_LAT - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                // Response fields are held until the consumer takes them.
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: three instances with read latencies 1, 3 and 4,
// a byte-lane memory model per instance and a response scoreboard queue.
module tb_data_memory_hs;
    localparam int N = 3;

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_we    [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic [3:0]  req_be    [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_we    [N];
    logic        rsp_err   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_memory_hs #(
            .DATA_W(32), .ADDR_W(32), .DEPTH(32),
            .RD_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4)), .ZERO_INIT(1)
        ) u_dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_be(req_be[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]),
            .rsp_we(rsp_we[g]), .rsp_err(rsp_err[g])
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        sb [$];
    logic [31:0] model [N][32];
    int          total = 0;
    int          bad = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    // Presents a request, waits for acceptance, pushes the expected response.
    task automatic send(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input bit hold, output int acyc);
        exp_t e;
        logic err;
        int   idx;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        req_valid[k] = 1'b1;
        for (int i = 0; i < 50 && !req_ready[k]; i++) @(negedge clk);
        if (!req_ready[k]) begin
            total++; bad++;
            $display("FAIL accept_timeout dut=%0d req_ready got=0 want=1", k);
        end
        acyc = cyc;
        err = (addr[1:0] != 2'b00) || (addr[31:7] != 25'd0);
        idx = int'(addr[6:2]);
        e.we = we;
        e.err = err;
        e.rdata = (we || err) ? 32'h0 : model[k][idx];
        if (we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[k][idx][b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        sb.push_back(e);
        @(negedge clk);
        if (!hold) req_valid[k] = 1'b0;
    endtask

    // Waits (bounded) for rsp_valid and captures the response.
    task automatic get_rsp(input int k, output int rcyc, output logic we, output logic err,
                           output logic [31:0] rdata, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rsp_valid[k]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rcyc = cyc;
        we = rsp_we[k];
        err = rsp_err[k];
        rdata = rsp_rdata[k];
        if (ok && rsp_ready[k]) @(negedge clk);
    endtask

    task automatic xact(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int lat, output logic o_we, output logic o_err,
                        output logic [31:0] o_rdata, output exp_t e, output bit ok);
        int a, r;
        send(k, we, addr, wdata, be, 1'b0, a);
        get_rsp(k, r, o_we, o_err, o_rdata, ok);
        e = sb.pop_front();
        lat = r - a;
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) begin
            total++;
            if ({req_ready[k], rsp_valid[k], rsp_we[k], rsp_err[k]} !== 4'b1000) begin
                bad++;
                $display("FAIL reset_ctrl dut=%0d got rdy/vld/we/err=%b want 1000", k,
                         {req_ready[k], rsp_valid[k], rsp_we[k], rsp_err[k]});
            end
            total++;
            if (rsp_rdata[k] !== 32'h0) begin
                bad++;
                $display("FAIL reset_rdata dut=%0d got=%h want=0", k, rsp_rdata[k]);
            end
        end
    endtask

    task automatic test_basic();
        int lat; logic w, er; logic [31:0] rd; exp_t e; bit ok;
        xact(0, 1'b1, 32'h0, 32'h28, 4'hF, lat, w, er, rd, e, ok);
        total++;
        if (!ok || lat !== 1) begin bad++; $display("FAIL basic_wr_latency got=%0d want=1", lat); end
        total++;
        if ({w, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
            bad++; $display("FAIL basic_wr_rsp got we=%b err=%b rdata=%h want we=1 err=0 rdata=0", w, er, rd);
        end
        xact(0, 1'b0, 32'h0, 32'h0, 4'hF, lat, w, er, rd, e, ok);
        total++;
        if (!ok || lat !== 1) begin bad++; $display("FAIL basic_rd_latency got=%0d want=1", lat); end
        total++;
        if ({w, er, rd} !== {1'b0, 1'b0, 32'h00000028}) begin
            bad++; $display("FAIL basic_rd_rsp got we=%b err=%b rdata=%h want we=0 err=0 rdata=00000028", w, er, rd);
        end
    endtask

    task automatic test_byte_enable();
        int lat; logic w, er; logic [31:0] rd; exp_t e; bit ok;
        xact(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'hF, lat, w, er, rd, e, ok);
        xact(0, 1'b1, 32'h4, 32'h11223344, 4'h5, lat, w, er, rd, e, ok);
        total++;
        if (!ok || {w, er, rd} !== {e.we, e.err, e.rdata}) begin
            bad++; $display("FAIL be_wr_rsp got we=%b err=%b rdata=%h want we=1 err=0 rdata=0", w, er, rd);
        end
        xact(0, 1'b0, 32'h4, 32'h0, 4'hF, lat, w, er, rd, e, ok);
        total++;
        if (!ok || rd !== 32'hAA22CC44 || er !== 1'b0) begin
            bad++; $display("FAIL be_merge got=%h err=%b want=aa22cc44 err=0", rd, er);
        end
        xact(0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, lat, w, er, rd, e, ok);
        total++;
        if (!ok || {w, er, rd} !== {1'b1, 1'b0, 32'h0}) begin
            bad++; $display("FAIL be_zero_rsp got we=%b err=%b rdata=%h want we=1 err=0 rdata=0", w, er, rd);
        end
        xact(0, 1'b0, 32'h4, 32'h0, 4'hF, lat, w, er, rd, e, ok);
        total++;
        if (!ok || rd !== 32'hAA22CC44) begin
            bad++; $display("FAIL be_zero_nochange got=%h want=aa22cc44", rd);
        end
    endtask

    task automatic test_errors();
        int lat; logic w, er; logic [31:0] rd; exp_t e; bit ok;
        xact(0, 1'b0, 32'h6, 32'h0, 4'hF, lat, w, er, rd, e, ok);
        total++;
        if (!ok || {er, rd} !== {1'b1, 32'h0} || {er, rd} !== {e.err, e.rdata}) begin
            bad++; $display("FAIL err_misaligned got err=%b rdata=%h want err=1 rdata=0", er, rd);
        end
        xact(0, 1'b0, 32'h80, 32'h0, 4'hF, lat, w, er, rd, e, ok);
        total++;
        if (!ok || {er, rd} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL err_range_rd got err=%b rdata=%h want err=1 rdata=0", er, rd);
        end
        xact(0, 1'b1, 32'h80, 32'hDEAD0000, 4'hF, lat, w, er, rd, e, ok);
        total++;
        if (!ok || {w, er, rd} !== {1'b1, 1'b1, 32'h0}) begin
            bad++; $display("FAIL err_range_wr got we=%b err=%b rdata=%h want we=1 err=1 rdata=0", w, er, rd);
        end
        xact(0, 1'b0, 32'h0, 32'h0, 4'hF, lat, w, er, rd, e, ok);
        total++;
        if (!ok || rd !== 32'h00000028 || rd !== e.rdata) begin
            bad++; $display("FAIL err_no_write got=%h want=00000028", rd);
        end
    endtask

    task automatic test_stall();
        int lat, a, r; logic w, er; logic [31:0] rd; exp_t e; bit ok;
        xact(1, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, lat, w, er, rd, e, ok);
        total++;
        if (!ok || lat !== 3) begin bad++; $display("FAIL stall_wr_latency got=%0d want=3", lat); end
        rsp_ready[1] = 1'b0;
        send(1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, a);
        get_rsp(1, r, w, er, rd, ok);
        e = sb.pop_front();
        total++;
        if (!ok || r - a !== 3 || rd !== 32'hCAFEF00D || rd !== e.rdata) begin
            bad++; $display("FAIL stall_rd got lat=%0d rdata=%h want lat=3 rdata=cafef00d", r - a, rd);
        end
        // A stray write presented while busy must be ignored.
        req_we[1] = 1'b1; req_addr[1] = 32'h4; req_wdata[1] = 32'h0BADBAD0; req_be[1] = 4'hF;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({rsp_valid[1], req_ready[1]} !== 2'b10 || rsp_rdata[1] !== 32'hCAFEF00D) begin
                bad++; $display("FAIL stall_hold cycle=%0d got vld=%b rdy=%b rdata=%h want vld=1 rdy=0 rdata=cafef00d",
                                i, rsp_valid[1], req_ready[1], rsp_rdata[1]);
            end
            @(negedge clk);
        end
        rsp_ready[1] = 1'b1;
        total++;
        if ({rsp_valid[1], req_ready[1]} !== 2'b10) begin
            bad++; $display("FAIL stall_hs_cycle got vld=%b rdy=%b want vld=1 rdy=0", rsp_valid[1], req_ready[1]);
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        total++;
        if ({rsp_valid[1], req_ready[1]} !== 2'b01) begin
            bad++; $display("FAIL stall_after_hs got vld=%b rdy=%b want vld=0 rdy=1", rsp_valid[1], req_ready[1]);
        end
        xact(1, 1'b0, 32'h4, 32'h0, 4'hF, lat, w, er, rd, e, ok);
        total++;
        if (!ok || rd !== 32'hCAFEF00D) begin
            bad++; $display("FAIL stall_ignored_req got=%h want=cafef00d", rd);
        end
    endtask

    task automatic test_reset_mid();
        int lat, a; logic w, er; logic [31:0] rd; exp_t e; bit ok; bit seen;
        xact(2, 1'b1, 32'h10, 32'h12345678, 4'hF, lat, w, er, rd, e, ok);
        total++;
        if (!ok || lat !== 4) begin bad++; $display("FAIL rstmid_wr_latency got=%0d want=4", lat); end
        send(2, 1'b0, 32'h14, 32'h0, 4'hF, 1'b0, a);
        e = sb.pop_front();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({req_ready[2], rsp_valid[2]} !== 2'b10) begin
            bad++; $display("FAIL rstmid_async got rdy=%b vld=%b want rdy=1 vld=0", req_ready[2], rsp_valid[2]);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid[2]) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp got rsp_valid=1 want 0"); end
        xact(2, 1'b0, 32'h10, 32'h0, 4'hF, lat, w, er, rd, e, ok);
        total++;
        if (!ok || rd !== 32'h12345678 || lat !== 4) begin
            bad++; $display("FAIL rstmid_keep got rdata=%h lat=%0d want rdata=12345678 lat=4", rd, lat);
        end
    endtask

    task automatic test_back_to_back(input int k);
        int a, r, prev_a; logic w, er; logic [31:0] rd; exp_t e; bit ok;
        logic [31:0] addr, data;
        prev_a = 0;
        rsp_ready[k] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = (i < 2) ? 32'h8 : 32'hC;
            data = $urandom;
            send(k, (i % 2 == 0), addr, data, 4'hF, 1'b1, a);
            get_rsp(k, r, w, er, rd, ok);
            e = sb.pop_front();
            total++;
            if (!ok || {w, er, rd} !== {e.we, e.err, e.rdata} || r - a !== lat_of(k)) begin
                bad++; $display("FAIL b2b_rsp dut=%0d i=%0d got we=%b err=%b rdata=%h lat=%0d want we=%b err=%b rdata=%h lat=%0d",
                                k, i, w, er, rd, r - a, e.we, e.err, e.rdata, lat_of(k));
            end
            if (i > 0) begin
                total++;
                if (a - prev_a !== lat_of(k) + 1) begin
                    bad++; $display("FAIL b2b_spacing dut=%0d i=%0d got=%0d want=%0d", k, i, a - prev_a, lat_of(k) + 1);
                end
            end
            prev_a = a;
        end
        req_valid[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 32'h0;
            req_wdata[k] = 32'h0; req_be[k] = 4'h0; rsp_ready[k] = 1'b1;
            for (int j = 0; j < 32; j++) model[k][j] = 32'h0;
        end
        @(negedge clk);
        @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_basic();
        test_byte_enable();
        test_errors();
        test_stall();
        test_reset_mid();
        test_back_to_back(0);
        test_back_to_back(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
